sipo_deser: RTL and testbench

Parametrised serial-to-parallel deserializer with a registered output word and a valid/ready handshake. It collects `WIDTH` serial bits (MSB- or LSB-first) and presents each completed word in a holding register until the consumer accepts it. A sticky flag records words that were dropped because the consumer was not ready. It sits between the serial input front-end and the parallel datapath and register stages.

---
 rtl/sipo_deser_pkg.sv | 15 +
 rtl/sipo_deser_if.sv | 33 +++
 rtl/sipo_shift.sv | 79 +++++++
 rtl/sipo_deser.sv | 100 ++++++++++
 tb/tb_sipo_deser.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_deser_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
// Shared helpers for the serial-to-parallel deserializer.
//   cnt_w(n)        : width of a counter that must hold the value n
//   SIPO_MAX_WIDTH  : largest supported word width
// -----------------------------------------------------------------------------
package sipo_pkg;

  localparam int SIPO_MAX_WIDTH = 32;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// -----------------------------------------------------------------------------
// sipo_deser_if
// Serial input and parallel output handshake bundle of sipo_deser.
//   enable, sof, data_in : serial bit stream (driven by the front-end)
//   out_data, out_valid  : completed word and its valid flag
//   out_ready            : consumer accept
//   overflow, parity_err : status flags
// Modports: slave = deserializer side, master = front-end/consumer side.
// -----------------------------------------------------------------------------
interface sipo_deser_if #(
  parameter int WIDTH = 8
) ();

  logic             enable;
  logic             sof;
  logic             data_in;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic             parity_err;

  modport slave (
    input  enable, sof, data_in, out_ready,
    output out_data, out_valid, overflow, parity_err
  );

  modport master (
    output enable, sof, data_in, out_ready,
    input  out_data, out_valid, overflow, parity_err
  );

endinterface

// File: rtl/sipo_shift.sv
// -----------------------------------------------------------------------------
// sipo_shift
// Shift register and bit counter of the deserializer. Collects NBITS serial
// bits and flags the cycle in which the last bit arrives; the completed word
// is formed combinationally from the stored bits plus the current data_in.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   enable, sof : bit qualifier and start-of-frame
//   data_in     : serial bit
//   word_done   : current bit completes a word
//   word        : WIDTH data bits of the completed word, in output bit order
//   parity_bit  : last received bit (the parity bit when NBITS = WIDTH+1)
// -----------------------------------------------------------------------------
module sipo_shift
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NBITS     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sof,
  input  logic             data_in,
  output logic             word_done,
  output logic [WIDTH-1:0] word,
  output logic             parity_bit
);

  localparam int CW = cnt_w(NBITS);
  // Only NBITS-1 bits need storing: the last one is taken straight from data_in.
  localparam int SW = NBITS - 1;

  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [SW-1:0]    sreg_reg, sreg_next;
  logic [CW-1:0]    bit_idx;
  logic [NBITS-1:0] full;
  logic [WIDTH-1:0] first_at_msb;

  // sof restarts the word, so the current bit is bit 0 regardless of cnt.
  assign bit_idx   = sof ? '0 : cnt_reg;
  assign word_done = enable && (bit_idx == CW'(NBITS - 1));

  always_comb begin
    cnt_next  = cnt_reg;
    sreg_next = sreg_reg;
    if (enable) begin
      cnt_next  = word_done ? '0 : bit_idx + 1'b1;
      sreg_next = sof ? SW'(data_in) : SW'({sreg_reg, data_in});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      sreg_reg <= '0;
    end else begin
      cnt_reg  <= cnt_next;
      sreg_reg <= sreg_next;
    end
  end

  // Oldest bit sits at the top of full; data bits precede the parity bit.
  assign full         = {sreg_reg, data_in};
  assign first_at_msb = full[NBITS-1 -: WIDTH];
  assign parity_bit   = full[0];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
      if (MSB_FIRST) begin : g_msb
        assign word[gi] = first_at_msb[gi];
      end else begin : g_lsb
        assign word[gi] = first_at_msb[WIDTH-1-gi];
      end
    end
  endgenerate

endmodule

// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser
// Serial-to-parallel deserializer with a registered holding word and a
// valid/ready handshake. A word completing while the previous one is still
// unaccepted is dropped and sets the sticky overflow flag.
// Optional macro SIPO_PARITY_EN: each word is followed by one even-parity bit
// and parity_err reports a mismatch for the word in out_data; when undefined,
// parity_err is tied to 0.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sipo_deser_if.slave (serial input, output word, handshake,
//              overflow, parity_err)
// -----------------------------------------------------------------------------
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  sipo_deser_if.slave  bus
);

`ifdef SIPO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  logic             word_done;
  logic [WIDTH-1:0] word;
  logic             parity_bit;

  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic             overflow_reg;
  logic             accept;
  logic             load;

  sipo_shift #(
    .WIDTH     (WIDTH),
    .NBITS     (NBITS),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .enable     (bus.enable),
    .sof        (bus.sof),
    .data_in    (bus.data_in),
    .word_done  (word_done),
    .word       (word),
    .parity_bit (parity_bit)
  );

  assign accept = out_valid_reg && bus.out_ready;
  // A completing word may replace the held one in the same edge it is accepted.
  assign load   = word_done && (!out_valid_reg || bus.out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (load) begin
        out_data_reg  <= word;
        out_valid_reg <= 1'b1;
      end else if (word_done) begin
        overflow_reg  <= 1'b1;
      end else if (accept) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  logic parity_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_reg <= 1'b0;
    end else if (load) begin
      parity_err_reg <= (^word) ^ parity_bit;
    end
  end

  assign bus.parity_err = parity_err_reg;
`else
  // Without parity the last received bit is an ordinary data bit.
  logic parity_unused;
  assign parity_unused  = parity_bit;
  assign bus.parity_err = 1'b0;
`endif

  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_sipo_deser.sv
// -----------------------------------------------------------------------------
// tb_sipo_deser
// Drives two deserializers (MSB-first and LSB-first) with the same serial
// stream. Expected words go into one queue per DUT when a word is sent and
// are popped whenever a DUT hands a word over (out_valid && out_ready).
// -----------------------------------------------------------------------------
module tb_sipo_deser;

  localparam int W = 8;
`ifdef SIPO_PARITY_EN
  localparam int NB  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = W;
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] data;
    logic         perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t q_m[$];
  exp_t q_l[$];

  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(W)) bus_m ();
  sipo_deser_if #(.WIDTH(W)) bus_l ();

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus_m));
  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l));

  // ---------------- scoreboard monitors (handshake seen before the edge) ----
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus_m.out_valid && bus_m.out_ready) begin
      total++;
      if (q_m.size() == 0) begin
        bad++;
        $display("FAIL sb_msb: got word %h, no word expected", bus_m.out_data);
      end else begin
        e = q_m.pop_front();
        if ({bus_m.out_data, bus_m.parity_err} !== e) begin
          bad++;
          $display("FAIL sb_msb: got %h perr=%b, expected %h perr=%b",
                   bus_m.out_data, bus_m.parity_err, e.data, e.perr);
        end else
          $display("accept msb: %h perr=%b", bus_m.out_data, bus_m.parity_err);
      end
    end
    if (!rst && bus_l.out_valid && bus_l.out_ready) begin
      total++;
      if (q_l.size() == 0) begin
        bad++;
        $display("FAIL sb_lsb: got word %h, no word expected", bus_l.out_data);
      end else begin
        e = q_l.pop_front();
        if ({bus_l.out_data, bus_l.parity_err} !== e) begin
          bad++;
          $display("FAIL sb_lsb: got %h perr=%b, expected %h perr=%b",
                   bus_l.out_data, bus_l.parity_err, e.data, e.perr);
        end else
          $display("accept lsb: %h perr=%b", bus_l.out_data, bus_l.parity_err);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic set_in(input logic en, input logic s, input logic d);
    bus_m.enable = en; bus_m.sof = s; bus_m.data_in = d;
    bus_l.enable = en; bus_l.sof = s; bus_l.data_in = d;
  endtask

  task automatic set_ready(input logic r);
    bus_m.out_ready = r;
    bus_l.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic d, input logic s);
    set_in(1'b1, s, d);
    tick();
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // seq holds the stream with its first bit at seq[W-1].
  task automatic push_exp(input logic [W-1:0] seq, input logic pb);
    logic perr;
    perr = PAR ? ((^seq) ^ pb) : 1'b0;
    q_m.push_back('{seq, perr});
    q_l.push_back('{rev(seq), perr});
  endtask

  task automatic send_word(input logic [W-1:0] seq, input bit first_sof,
                           input bit bad_par, input bit keep, input bit gaps);
    logic pb;
    pb = (^seq) ^ bad_par;
    if (keep) push_exp(seq, pb);
    for (int i = 0; i < NB; i++) begin
      logic d;
      d = (i < W) ? seq[W-1-i] : pb;
      drive_bit(d, first_sof && (i == 0));
      if (gaps && i != NB - 1) idle($urandom_range(1, 4));
    end
    $display("sent word %h sof=%0b badpar=%0b keep=%0b gaps=%0b", seq, first_sof, bad_par, keep, gaps);
  endtask

  // ---------------- scenarios -----------------------------------------------
  task automatic test_reset();
    set_in(1'b0, 1'b0, 1'b0);
    set_ready(1'b0);
    rst = 1'b1;
    repeat (3) tick();
    total += 2;
    if ({bus_m.out_data, bus_m.out_valid, bus_m.overflow, bus_m.parity_err} !== '0) begin
      bad++;
      $display("FAIL reset_msb: data=%h valid=%b ovf=%b perr=%b, expected all 0",
               bus_m.out_data, bus_m.out_valid, bus_m.overflow, bus_m.parity_err);
    end
    if ({bus_l.out_data, bus_l.out_valid, bus_l.overflow, bus_l.parity_err} !== '0) begin
      bad++;
      $display("FAIL reset_lsb: data=%h valid=%b ovf=%b perr=%b, expected all 0",
               bus_l.out_data, bus_l.out_valid, bus_l.overflow, bus_l.parity_err);
    end
    rst = 1'b0;
    tick();
    $display("reset applied");
  endtask

  task automatic test_basic();
    set_ready(1'b1);
    send_word(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus_m.out_valid !== 1'b1 || bus_m.out_data !== 8'hA5 || bus_l.out_data !== 8'hA5) begin
      bad++;
      $display("FAIL basic_a5: valid=%b msb=%h lsb=%h, expected 1 a5 a5",
               bus_m.out_valid, bus_m.out_data, bus_l.out_data);
    end
    idle(1);
    total++;
    if (bus_m.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulse: valid=%b, expected 0 one cycle later", bus_m.out_valid);
    end
    send_word(8'hC0, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus_m.out_data !== 8'hC0 || bus_l.out_data !== 8'h03) begin
      bad++;
      $display("FAIL basic_c0: msb=%h lsb=%h, expected c0 03", bus_m.out_data, bus_l.out_data);
    end
    idle(1);
  endtask

  task automatic test_sof();
    set_ready(1'b1);
    for (int g = 0; g < 2; g++) begin
      drive_bit(1'b1, 1'b0);
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b1, 1'b0);
      idle(2);
      send_word(8'h3C, 1'b1, 1'b0, 1'b1, g[0]);
      total++;
      if (bus_m.out_valid !== 1'b1 || bus_m.out_data !== 8'h3C || bus_l.out_data !== rev(8'h3C)) begin
        bad++;
        $display("FAIL sof_gap%0d: valid=%b msb=%h lsb=%h, expected 1 3c %h",
                 g, bus_m.out_valid, bus_m.out_data, bus_l.out_data, rev(8'h3C));
      end
      idle(1);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] seqs [3];
    int pulses;
    int drops;
    seqs[0] = 8'hF0; seqs[1] = 8'h0F; seqs[2] = 8'h5A;
    // Continuous stream, consumer always ready: one valid cycle per word.
    set_ready(1'b1);
    pulses = 0;
    for (int w = 0; w < 3; w++) begin
      push_exp(seqs[w], ^seqs[w]);
      for (int i = 0; i < NB; i++) begin
        drive_bit((i < W) ? seqs[w][W-1-i] : ^seqs[w], 1'b0);
        if (bus_m.out_valid === 1'b1) pulses++;
      end
    end
    total++;
    if (pulses !== 3) begin
      bad++;
      $display("FAIL b2b_pulses: valid cycles=%0d, expected 3", pulses);
    end
    idle(1);
    // Accept of F0 coincides with completion of 0F.
    set_ready(1'b0);
    send_word(8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(8'h0F, ^8'h0F);
    drops = 0;
    for (int i = 0; i < NB; i++) begin
      if (i == NB - 1) set_ready(1'b1);
      drive_bit((i < W) ? seqs[1][W-1-i] : ^seqs[1], 1'b0);
      if (bus_m.out_valid !== 1'b1) drops++;
    end
    total++;
    if (drops !== 0 || bus_m.out_data !== 8'h0F || bus_m.overflow !== 1'b0 || bus_l.overflow !== 1'b0) begin
      bad++;
      $display("FAIL b2b_same_cycle: drops=%0d data=%h ovf=%b/%b, expected 0 0f 0/0",
               drops, bus_m.out_data, bus_m.overflow, bus_l.overflow);
    end
    idle(1);
    set_ready(1'b0);
  endtask

  task automatic test_overflow();
    set_ready(1'b0);
    send_word(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    total++;
    if (bus_m.out_valid !== 1'b1 || bus_m.out_data !== 8'h11 || bus_m.overflow !== 1'b1 ||
        bus_l.out_data !== 8'h88 || bus_l.overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_hold: valid=%b msb=%h ovf=%b lsb=%h ovf=%b, expected 1 11 1 88 1",
               bus_m.out_valid, bus_m.out_data, bus_m.overflow, bus_l.out_data, bus_l.overflow);
    end
    set_ready(1'b1);
    tick();
    set_ready(1'b0);
    total++;
    if (bus_m.out_valid !== 1'b0 || bus_m.overflow !== 1'b1 || bus_l.overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: valid=%b ovf=%b/%b, expected 0 1/1",
               bus_m.out_valid, bus_m.overflow, bus_l.overflow);
    end
  endtask

  task automatic test_rst_midword();
    set_ready(1'b0);
    send_word(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    total++;
    if ({bus_m.out_data, bus_m.out_valid, bus_m.overflow, bus_m.parity_err,
         bus_l.out_data, bus_l.out_valid, bus_l.overflow, bus_l.parity_err} !== '0) begin
      bad++;
      $display("FAIL rst_async: msb data=%h valid=%b ovf=%b, lsb data=%h valid=%b ovf=%b, expected all 0",
               bus_m.out_data, bus_m.out_valid, bus_m.overflow,
               bus_l.out_data, bus_l.out_valid, bus_l.overflow);
    end
    q_m.delete();
    q_l.delete();
    tick();
    rst = 1'b0;
    tick();
    set_ready(1'b1);
    send_word(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus_m.out_valid !== 1'b1 || bus_m.out_data !== 8'h5A || bus_l.out_data !== 8'h5A) begin
      bad++;
      $display("FAIL rst_next_word: valid=%b msb=%h lsb=%h, expected 1 5a 5a",
               bus_m.out_valid, bus_m.out_data, bus_l.out_data);
    end
    idle(1);
  endtask

  task automatic test_parity();
    set_ready(1'b1);
    send_word(8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus_m.parity_err !== 1'b0 || bus_l.parity_err !== 1'b0) begin
      bad++;
      $display("FAIL parity_good: perr=%b/%b, expected 0/0", bus_m.parity_err, bus_l.parity_err);
    end
    idle(1);
    send_word(8'h07, 1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (bus_m.parity_err !== PAR || bus_l.parity_err !== PAR) begin
      bad++;
      $display("FAIL parity_bad: perr=%b/%b, expected %b", bus_m.parity_err, bus_l.parity_err, PAR);
    end
    idle(1);
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0);
    set_ready(1'b0);
    test_reset();
    test_basic();
    test_sof();
    test_back_to_back();
    test_overflow();
    test_rst_midword();
    test_parity();
    idle(2);
    total++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: words left msb=%0d lsb=%0d, expected 0", q_m.size(), q_l.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
